// File: rtl/sap_core.sv
// sap_core: SAP-1 style accumulator CPU with a front-panel program/clear port.
// Define SAP_CORE_FLAGS_EN to build the Z/C flags and the JZ/JC opcodes.
module sap_core #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          fp_clear,
    input  logic          fp_prog,
    input  logic          fp_write,
    input  logic [AW-1:0] fp_adr,
    input  logic [DW-1:0] fp_data,
    output logic [DW-1:0] o_out,
    output logic          hlt,
    output logic [5:0]    t_state,
    output logic [AW-1:0] pc_out,
    output logic [1:0]    flags
);
    localparam logic [6:0] T1   = 7'b0000001;
    localparam logic [6:0] T2   = 7'b0000010;
    localparam logic [6:0] T3   = 7'b0000100;
    localparam logic [6:0] T4   = 7'b0001000;
    localparam logic [6:0] T5   = 7'b0010000;
    localparam logic [6:0] T6   = 7'b0100000;
    localparam logic [6:0] HALT = 7'b1000000;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JZ  = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [6:0]    state;
    logic [AW-1:0] pc;
    logic [AW-1:0] mar;
    logic [DW-1:0] ir;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
    logic [3:0]    op;
    logic [AW-1:0] operand;
    logic          sub;
    logic          alu_op;
    logic          take;
    logic          sta_we;
    logic [DW-1:0] res;

    assign op      = ir[DW-1:DW-4];
    assign operand = ir[AW-1:0];
    assign sub     = op == OP_SUB;
    assign alu_op  = op == OP_ADD || sub;
    assign addr    = fp_prog ? fp_adr : mar;
    assign rdata   = mem[addr];
    assign t_state = state[5:0];
    assign hlt     = state[6];
    assign pc_out  = pc;
    assign sta_we  = !fp_clear && !fp_prog && state == T5 && op == OP_STA;

`ifdef SAP_CORE_FLAGS_EN
    logic [DW:0] sum;
    logic        z;
    logic        c;
    // SUB is A + ~B + 1, so the carry-out doubles as not-borrow
    assign sum   = {1'b0, a} + {1'b0, sub ? ~b : b} + (DW+1)'(sub);
    assign res   = sum[DW-1:0];
    assign flags = {c, z};
    assign take  = (op == OP_JZ && z) || (op == OP_JC && c);
    always_ff @(posedge clk) begin
        if (fp_clear) begin
            z <= 1'b0;
            c <= 1'b0;
        end else if (!fp_prog && state == T6) begin
            z <= res == '0;
            c <= sum[DW];
        end
    end
`else
    assign res   = a + (sub ? ~b : b) + DW'(sub);
    assign flags = 2'b00;
    assign take  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (fp_clear) begin
            state <= T1;
            pc    <= '0;
            mar   <= '0;
            ir    <= '0;
            a     <= '0;
            b     <= '0;
            o_out <= '0;
        end else if (!fp_prog) begin
            case (state)
                T1: begin
                    mar   <= pc;
                    state <= T2;
                end
                T2: begin
                    pc    <= pc + 1'b1;
                    state <= T3;
                end
                T3: begin
                    ir    <= rdata;
                    state <= T4;
                end
                T4: begin
                    state <= T1;
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            mar   <= operand;
                            state <= T5;
                        end
                        OP_LDI: a <= DW'(operand);
                        OP_JMP: pc <= operand;
                        OP_JZ, OP_JC: if (take) pc <= operand;
                        OP_OUT: o_out <= a;
                        OP_HLT: state <= HALT;
                        default: ;
                    endcase
                end
                T5: begin
                    state <= alu_op ? T6 : T1;
                    if (op == OP_LDA) a <= rdata;
                    if (alu_op) b <= rdata;
                end
                T6: begin
                    a     <= res;
                    state <= T1;
                end
                default: state <= HALT;
            endcase
        end
    end

    // memory is deliberately outside the reset domain
    always_ff @(posedge clk) begin
        if (fp_prog && fp_write) mem[fp_adr] <= fp_data;
        else if (sta_we) mem[mar] <= a;
    end
endmodule

// File: doc/sap_core.md
SAP_CORE -- requirements
Module: sap_core

Interface
REQ-001 Parameter DW, default 8: data, accumulator and memory word width; legal range 8..16.
REQ-002 Parameter AW, default 4: address width; memory depth is 2^AW words; DW SHALL be at least AW+4.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 fp_clear  input  1  reset, synchronous, active-high.
REQ-005 fp_prog  input  1  program mode; the core is frozen and the memory is addressed by fp_adr.
REQ-006 fp_write  input  1  memory write strobe, honoured only while fp_prog=1.
REQ-007 fp_adr  input  AW  program-mode address.
REQ-008 fp_data  input  DW  program-mode write data.
REQ-009 o_out  output  DW  output register.
REQ-010 hlt  output  1  high while the core is halted.
REQ-011 t_state  output  6  one-hot T1..T6 (bit0=T1); all zero while halted.
REQ-012 pc_out  output  AW  current PC.
REQ-013 flags  output  2  {C,Z}.

Function
REQ-014 Opcode = IR[DW-1:DW-4]; operand = IR[AW-1:0]; IR bits between them are ignored.
REQ-015 Opcodes: 0 LDA, 1 ADD, 2 SUB, 3 STA, 4 LDI, 5 JMP, 6 JZ, 7 JC, E OUT, F HLT; all others NOP.
REQ-016 Fetch, one state per clock: T1 MAR<=PC; T2 PC<=PC+1 modulo 2^AW (wraps to 0); T3 IR<=mem[MAR].
REQ-017 Execute, T4 onward:
- LDA: T4 MAR<=operand; T5 A<=mem[MAR].
- ADD/SUB: T4 MAR<=operand; T5 B<=mem[MAR]; T6 A<=A+B or A-B (DW bits); Z set when the result is 0; C = carry-out for ADD, not-borrow for SUB.
- STA: T4 MAR<=operand; T5 mem[MAR]<=A.
- LDI: T4 A<=operand zero-extended.
- JMP: T4 PC<=operand. JZ/JC: T4 PC<=operand if Z/C is set, otherwise no change.
- OUT: T4 o_out<=A. NOP: T4 no operation.
REQ-018 After the last execute state of an instruction, the next state is T1; there are no idle states (4/5/6-cycle instructions).
REQ-019 Only ADD and SUB modify flags.
REQ-020 HLT: at T4, enter HALT; hlt=1 on the next cycle; the core stays in HALT until fp_clear; fp_prog has no effect on HALT.
REQ-021 While fp_prog=1, the state, PC, A, B, O and flags SHALL hold; the memory address is fp_adr, and fp_write=1 writes mem[fp_adr]<=fp_data at the edge.
REQ-022 Deasserting fp_prog resumes at the held state.
REQ-023 A core-side STA write and a program-port write never coincide; fp_prog has priority.
REQ-024 The memory read is combinational from the selected address; writes are synchronous; writes to the current address are visible in the next cycle.

Reset
REQ-025 While fp_clear=1 at an edge: t_state=T1, PC=0, MAR=0, IR=0, A=0, B=0, o_out=0, flags=0 and hlt=0, taking effect from the following cycle.
REQ-026 Memory contents SHALL NOT be affected by fp_clear.
REQ-027 fp_clear asserted mid-instruction aborts it; a pending STA write in that cycle SHALL NOT occur; fp_clear has priority over fp_prog.

Configuration
REQ-028 Macro SAP_CORE_FLAGS_EN: when defined, flags Z/C and opcodes JZ/JC are implemented as in REQ-017.
REQ-029 When SAP_CORE_FLAGS_EN is undefined: no flag registers, flags output tied to 0, and opcodes 6 and 7 execute as NOP (4 cycles).

Verification
REQ-030 DW=8, AW=4; load via the program port mem[0..4]={0x09,0x1A,0xE0,0xF0,0}, mem[9]=0x1C, mem[A]=0x0E; clear; run -> o_out=0x2A, hlt=1, LDA 5 + ADD 6 + OUT 4 + HLT 4 cycles before hlt rises.
REQ-031 SUB to zero: mem[9]=0x05, program LDA 9, SUB 9, JZ 7, OUT, HLT at 7 -> flags Z=1 C=1, jump taken, o_out stays 0x00.
REQ-032 LDI/STA/wrap: LDI 3, STA F with PC run past 0xF -> mem[F]=0x03; PC wraps 0xF->0x0 without error.
REQ-033 Program-mode freeze: assert fp_prog at T5 of ADD for 10 cycles, write mem[2] -> state, PC and A unchanged; resume completes ADD with the correct sum.
REQ-034 Reset mid-STA at T5 -> target memory word unchanged; the next cycle shows t_state=6'b000001 and pc_out=0.
REQ-035 Build without SAP_CORE_FLAGS_EN: JZ with a zero result does not jump; flags=2'b00 throughout.
